ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Instruction-fetch stage directly upstream of imem: owns the fetch PC, drives imem addr,
//  captures the combinational instr into a DEPTH-entry prefetch queue and presents
//  {pc, npc, instr} to decode through a valid/ready handshake.
//  Absorbs decode stalls without re-fetching; supports redirect (branch/jump) with queue flush.
// PARAMETERS
//  RESET_PC     32'h0   fetch PC loaded by reset
//  DEPTH        2       prefetch queue entries (power of 2, >=2)
//  IMEM_OFFSET  32'h0   lowest legal fetch address (matches imem OFFSET)
//  IMEM_SIZE    4096    imem size in bytes (matches imem SIZE)
// PORTS
//  clk          in   1      clock, all state updates on posedge
//  reset        in   1      synchronous, active-high
//  imem_addr    out  [0:31] fetch address to imem (= fetch_pc, combinational from register)
//  imem_instr   in   [0:31] instruction word returned combinationally by imem
//  redirect     in   1      load redirect_pc, flush queue
//  redirect_pc  in   [0:31] new fetch target
//  halt         in   1      stop issuing new fetches (queue still drains)
//  out_valid    out  1      queue head valid
//  out_ready    in   1      decode accepts head this cycle
//  out_instr    out  [0:31] head instruction
//  out_pc       out  [0:31] head PC
//  out_npc      out  [0:31] head PC + 4
//  out_fault    out  1      head fetched outside imem window (see CONFIGURATION)
//  align_err    out  1      one-cycle pulse: last redirect_pc had [30:31] != 0
// BEHAVIOUR
//  - Bit 0 is MSB throughout; word alignment bits are [30:31].
//  - Reset: fetch_pc=RESET_PC, queue empty, out_valid=0, out_instr/out_pc/out_npc=0,
//    out_fault=0, align_err=0. Reset overrides redirect and all handshakes.
//  - pop  = out_valid & out_ready.
//  - push = !redirect & !halt & !stopped & (count<DEPTH | pop). On push: entry
//    {fetch_pc, fetch_pc+4, imem_instr, fault} written at tail; fetch_pc <= fetch_pc+4
//    (mod 2^32, 32'hFFFFFFFC wraps to 0).
//  - count' = count + push - pop; push and pop in same cycle legal at full and at count=1.
//  - Head outputs driven from queue storage; out_valid = (count!=0). Latency: fetch in
//    cycle N visible at out_* in cycle N+1 when queue was empty.
//  - Throughput: 1 instr/cycle sustained while out_ready=1 and no redirect.
//  - out_* hold stable while out_valid & !out_ready.
//  - Redirect (priority over push/pop): queue cleared (count=0), fetch_pc <=
//    {redirect_pc[0:29],2'b00}, stopped cleared; next cycle out_valid=0 and fetch of target.
//    A pop coinciding with redirect is discarded by consumer (treated as killed).
//  - align_err <= redirect & |redirect_pc[30:31]; else 0.
//  - halt: no push; pop continues; fetch_pc frozen. Deassert resumes at frozen fetch_pc.
// CONFIGURATION
//  IFETCH_BOUND_CHECK_EN defined: push computes fault = (fetch_pc < IMEM_OFFSET) |
//    (fetch_pc > IMEM_OFFSET+IMEM_SIZE-4). Faulting entry stores instr=32'h0, fault=1, and
//    sets stopped=1 (no further pushes until redirect or reset).
//  Not defined: fault always 0, out_fault tied 0, stopped never set; port still present.
// TESTING
//  1 Reset, RESET_PC=0, out_ready=1 -> out_pc 0,4,8,... one per cycle from cycle 1; npc=pc+4.
//  2 out_ready=0 for 5 cycles after reset -> count saturates at DEPTH, imem_addr holds
//    RESET_PC+4*DEPTH, out_pc holds 0; release -> pcs continue gap-free, no duplicates.
//  3 Redirect redirect_pc=32'h40 while full -> next cycle out_valid=0, imem_addr=32'h40;
//    following cycle out_pc=32'h40; no stale entry emerges.
//  4 Redirect redirect_pc=32'h43 -> align_err=1 for one cycle, fetch at 32'h40.
//  5 Redirect to 32'hFFFFFFFC, checks off -> out_pc FFFFFFFC then 00000000.
//  6 IFETCH_BOUND_CHECK_EN, IMEM_SIZE=16: run from 0 -> pcs 0..C normal, pc 10 has
//    out_fault=1 instr=0, no further entries; redirect 0 restarts cleanly.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, prefetches into a DEPTH-entry queue, feeds decode.
// Optional imem window check is enabled by defining IFETCH_BOUND_CHECK_EN.
module ifetch_queue #(
    parameter logic [0:31] RESET_PC    = 32'h0,
    parameter int          DEPTH       = 2,
    parameter logic [0:31] IMEM_OFFSET = 32'h0,
    parameter int unsigned IMEM_SIZE   = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic [0:31] imem_addr,
    input  logic [0:31] imem_instr,
    input  logic        redirect,
    input  logic [0:31] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] out_instr,
    output logic [0:31] out_pc,
    output logic [0:31] out_npc,
    output logic        out_fault,
    output logic        align_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [0:31]     fetch_pc;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [AW:0]     count;
    logic [0:31]     pc_mem    [DEPTH];
    logic [0:31]     npc_mem   [DEPTH];
    logic [0:31]     instr_mem [DEPTH];
    logic [DEPTH-1:0] fault_mem;

    logic        stopped;
    logic        fault;
    logic        pop;
    logic        push;
    logic [0:31] entry_instr;

`ifdef IFETCH_BOUND_CHECK_EN
    localparam logic [0:31] LAST_ADDR = 32'(IMEM_OFFSET + IMEM_SIZE - 32'd4);

    assign fault = (fetch_pc < IMEM_OFFSET) | (fetch_pc > LAST_ADDR);

    // A faulting fetch parks the stage until software steers it somewhere legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            stopped <= 1'b0;
        end else if (redirect) begin
            stopped <= 1'b0;
        end else if (push && fault) begin
            stopped <= 1'b1;
        end
    end
`else
    assign fault   = 1'b0;
    assign stopped = 1'b0;
`endif

    // Handshake: decode takes the head on any cycle where out_valid & out_ready; while
    // out_valid is high and out_ready low the head payload is held unchanged.
    assign out_valid   = (count != '0);
    assign pop         = out_valid & out_ready;
    assign push        = !redirect & !halt & !stopped & ((count != CNT_FULL) | pop);
    assign entry_instr = fault ? 32'h0 : imem_instr;

    assign imem_addr = fetch_pc;
    assign out_pc    = pc_mem[head];
    assign out_npc   = npc_mem[head];
    assign out_instr = instr_mem[head];
    assign out_fault = fault_mem[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            align_err <= 1'b0;
            fault_mem <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                npc_mem[i]   <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            align_err <= redirect & |redirect_pc[30:31];
            if (redirect) begin
                // Anything in flight belongs to the abandoned path, including a same-cycle pop.
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= {redirect_pc[0:29], 2'b00};
            end else begin
                if (push) begin
                    pc_mem[tail]    <= fetch_pc;
                    npc_mem[tail]   <= fetch_pc + 32'd4;
                    instr_mem[tail] <= entry_instr;
                    fault_mem[tail] <= fault;
                    tail            <= tail + PTR_ONE;
                    fetch_pc        <= fetch_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: randomized and directed stimulus against a queue-based model.
// Build with IFETCH_BOUND_CHECK_EN defined to exercise the imem window check (16-byte imem).
module tb_ifetch_queue;

    localparam logic [0:31] RESET_PC    = 32'h0;
    localparam int          DEPTH       = 2;
    localparam logic [0:31] IMEM_OFFSET = 32'h0;
`ifdef IFETCH_BOUND_CHECK_EN
    localparam int unsigned TB_IMEM_SIZE = 16;
`else
    localparam int unsigned TB_IMEM_SIZE = 4096;
`endif

    logic        clk;
    logic        reset;
    logic [0:31] imem_addr;
    logic [0:31] imem_instr;
    logic        redirect;
    logic [0:31] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] out_instr;
    logic [0:31] out_pc;
    logic [0:31] out_npc;
    logic        out_fault;
    logic        align_err;

    // Reference model: queue of fetched PCs plus the architectural fetch state.
    logic [0:31] exp_q[$];
    logic [0:31] m_pc;
    logic        m_stopped;
    logic        m_align;
    int          checks;
    int          passes;

    ifetch_queue #(
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH),
        .IMEM_OFFSET(IMEM_OFFSET),
        .IMEM_SIZE(TB_IMEM_SIZE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_instr(imem_instr),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_npc(out_npc),
        .out_fault(out_fault),
        .align_err(align_err)
    );

    function automatic logic [0:31] imem_fn(input logic [0:31] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic exp_fault(input logic [0:31] pc);
`ifdef IFETCH_BOUND_CHECK_EN
        logic [0:31] last;
        last = IMEM_OFFSET + TB_IMEM_SIZE - 32'd4;
        return (pc < IMEM_OFFSET) || (pc > last);
`else
        return (pc == 32'h0) && (pc != 32'h0);
`endif
    endfunction

    assign imem_instr = imem_fn(imem_addr);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        out_ready   = 1'b1;
        halt        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        m_pc      = RESET_PC;
        m_stopped = 1'b0;
        m_align   = 1'b0;
    endtask

    // ---------------- driver + scoreboard (one clock per call, entered at negedge) ----------------
    task automatic step(input logic rd, input logic [0:31] rpc, input logic h, input logic rdy);
        logic        e_valid;
        logic        e_pop;
        logic        e_push;
        logic [0:31] hpc;
        logic [0:31] e_instr;
        logic        e_flt;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = h;
        out_ready   = rdy;
        #1;
        e_valid = (exp_q.size() != 0);
        checks++;
        if (out_valid !== e_valid) $display("FAIL out_valid: got %0b want %0b t=%0t", out_valid, e_valid, $time);
        else passes++;
        checks++;
        if (imem_addr !== m_pc) $display("FAIL imem_addr: got %h want %h t=%0t", imem_addr, m_pc, $time);
        else passes++;
        checks++;
        if (align_err !== m_align) $display("FAIL align_err: got %0b want %0b t=%0t", align_err, m_align, $time);
        else passes++;
        if (e_valid) begin
            hpc     = exp_q[0];
            e_flt   = exp_fault(hpc);
            e_instr = e_flt ? 32'h0 : imem_fn(hpc);
            checks++;
            if (out_pc !== hpc) $display("FAIL out_pc: got %h want %h t=%0t", out_pc, hpc, $time);
            else passes++;
            checks++;
            if (out_npc !== hpc + 32'd4) $display("FAIL out_npc: got %h want %h t=%0t", out_npc, hpc + 32'd4, $time);
            else passes++;
            checks++;
            if (out_instr !== e_instr) $display("FAIL out_instr: got %h want %h t=%0t", out_instr, e_instr, $time);
            else passes++;
            checks++;
            if (out_fault !== e_flt) $display("FAIL out_fault: got %0b want %0b t=%0t", out_fault, e_flt, $time);
            else passes++;
        end
        e_pop  = e_valid & rdy;
        e_push = !rd & !h & !m_stopped & ((exp_q.size() < DEPTH) | e_pop);
        @(posedge clk);
        if (rd) begin
            exp_q.delete();
            m_pc      = {rpc[0:29], 2'b00};
            m_stopped = 1'b0;
        end else begin
            if (e_pop) void'(exp_q.pop_front());
            if (e_push) begin
                exp_q.push_back(m_pc);
                if (exp_fault(m_pc)) m_stopped = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
        m_align = rd & |rpc[30:31];
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid);
        else passes++;
        checks++;
        if (out_pc !== 32'h0 || out_npc !== 32'h0 || out_instr !== 32'h0)
            $display("FAIL reset_payload: got pc=%h npc=%h instr=%h want zeros", out_pc, out_npc, out_instr);
        else passes++;
        checks++;
        if (out_fault !== 1'b0 || align_err !== 1'b0)
            $display("FAIL reset_flags: got fault=%0b align=%0b want 0", out_fault, align_err);
        else passes++;
        checks++;
        if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC);
        else passes++;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (imem_addr !== RESET_PC + 32'(4 * DEPTH))
            $display("FAIL stall_addr: got %h want %h", imem_addr, RESET_PC + 32'(4 * DEPTH));
        else passes++;
        checks++;
        if (out_pc !== RESET_PC) $display("FAIL stall_head: got %h want %h", out_pc, RESET_PC);
        else passes++;
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_redirect_full();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h40, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h40)
            $display("FAIL redirect_next: got valid=%0b addr=%h want 0/00000040", out_valid, imem_addr);
        else passes++;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40)
            $display("FAIL redirect_head: got valid=%0b pc=%h want 1/00000040", out_valid, out_pc);
        else passes++;
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_align();
        step(1'b1, 32'h43, 1'b0, 1'b1);
        checks++;
        if (align_err !== 1'b1 || imem_addr !== 32'h40)
            $display("FAIL align_pulse: got err=%0b addr=%h want 1/00000040", align_err, imem_addr);
        else passes++;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (align_err !== 1'b0) $display("FAIL align_clear: got %0b want 0", align_err);
        else passes++;
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        step(1'b1, 32'hFFFFFFFC, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
`ifndef IFETCH_BOUND_CHECK_EN
        checks++;
        if (out_pc !== 32'hFFFFFFFC) $display("FAIL wrap_first: got %h want fffffffc", out_pc);
        else passes++;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (out_pc !== 32'h0 || out_npc !== 32'h4)
            $display("FAIL wrap_second: got pc=%h npc=%h want 00000000/00000004", out_pc, out_npc);
        else passes++;
`endif
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
    endtask

`ifdef IFETCH_BOUND_CHECK_EN
    task automatic test_bound_check();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || imem_addr !== 32'h14)
            $display("FAIL bound_stop: got valid=%0b addr=%h want 0/00000014", out_valid, imem_addr);
        else passes++;
        step(1'b1, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 11) == 0), 32'($urandom_range(0, 48)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
        end
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        halt        = 1'b0;
        out_ready   = 1'b0;
        m_pc        = RESET_PC;
        m_stopped   = 1'b0;
        m_align     = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_align();
        test_wrap();
        test_halt();
`ifdef IFETCH_BOUND_CHECK_EN
        test_bound_check();
`endif
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
